// File: rtl/pipe_pack.sv
// -----------------------------------------------------------------------------
// pipe_pack
//
// Packs RATIO consecutive DWIDTH-bit beats into one wide word. Each wide word
// carries per-lane keep bits and a last flag. The wide word sits on a
// registered valid/ready output. An input beat tagged i_last closes a
// partially filled word early. The block sustains one narrow beat per cycle
// while the wide side is not back-pressured.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rstn     : synchronous active-low reset
//   i_data   : narrow beat from upstream
//   i_valid  : narrow beat valid
//   i_last   : narrow beat closes the packet (qualified by i_valid)
//   o_ready  : narrow beat is accepted this cycle when i_valid is high
//   o_data   : packed wide word, lane k = bits [k*DWIDTH +: DWIDTH]
//   o_keep   : lane k holds valid data when bit k is set
//   o_last   : wide word closes a packet
//   o_valid  : wide word valid
//   i_ready  : downstream accepts the wide word
// -----------------------------------------------------------------------------
module pipe_pack #(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DWIDTH-1:0]        i_data,
    input  logic                     i_valid,
    input  logic                     i_last,
    output logic                     o_ready,
    output logic [DWIDTH*RATIO-1:0]  o_data,
    output logic [RATIO-1:0]         o_keep,
    output logic                     o_last,
    output logic                     o_valid,
    input  logic                     i_ready
);

    localparam int CW = $clog2(RATIO);

    // Number of lanes already filled in the word under construction.
    logic [CW-1:0]                   cnt_reg, cnt_next;
    // Lanes collected so far. Unwritten lanes stay zero.
    logic [RATIO-1:0][DWIDTH-1:0]    acc_reg, acc_next;
    // Word formed if the current beat closes it.
    logic [RATIO-1:0][DWIDTH-1:0]    word;
    logic [RATIO-1:0]                keep;

    logic [DWIDTH*RATIO-1:0]         data_reg, data_next;
    logic [RATIO-1:0]                keep_reg, keep_next;
    logic                            last_reg, last_next;
    logic                            valid_reg, valid_next;

    logic                            accept;
    logic                            transfer;
    logic                            close;

    // Stall only while a held word is refused downstream. A word that drains
    // this cycle frees the output register for a closing beat on the same edge.
    assign o_ready  = rstn && !(valid_reg && !i_ready);
    assign accept   = i_valid && o_ready;
    assign transfer = valid_reg && i_ready;
    assign close    = i_last || (cnt_reg == CW'(RATIO - 1));

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            // The current beat lands in lane cnt. Lanes below it come from
            // the accumulator. Lanes above it are forced to zero.
            assign word[gi] = (gi == int'(cnt_reg)) ? i_data :
                              (gi <  int'(cnt_reg)) ? acc_reg[gi] :
                                                      {DWIDTH{1'b0}};
            assign keep[gi] = (gi <= int'(cnt_reg));

            // A closing beat empties the accumulator for the next word.
            // Any other accepted beat writes only its own lane.
            assign acc_next[gi] = (accept && close)                       ? {DWIDTH{1'b0}} :
                                  (accept && (gi == int'(cnt_reg)))       ? i_data :
                                                                            acc_reg[gi];
        end
    endgenerate

    always_comb begin
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        keep_next  = keep_reg;
        last_next  = last_reg;
        valid_next = valid_reg;

        if (transfer) begin
            valid_next = 1'b0;
        end

        if (accept) begin
            if (close) begin
                // A word that closes on a transfer edge overrides the clear.
                // This keeps the output stream free of bubbles.
                data_next  = word;
                keep_next  = keep;
                last_next  = i_last;
                valid_next = 1'b1;
                cnt_next   = '0;
            end else begin
                cnt_next   = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            data_reg  <= '0;
            keep_reg  <= '0;
            last_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            data_reg  <= data_next;
            keep_reg  <= keep_next;
            last_reg  <= last_next;
            valid_reg <= valid_next;
        end
    end

    assign o_data  = data_reg;
    assign o_keep  = keep_reg;
    assign o_last  = last_reg;
    assign o_valid = valid_reg;

endmodule

// File: tb/tb_pipe_pack.sv
// -----------------------------------------------------------------------------
// tb_pipe_pack
//
// Bench for pipe_pack with DWIDTH=8 and RATIO=4. The stimulus side pushes each
// expected wide word into a queue. A negedge monitor pops the queue on every
// wide transfer and compares the word. It prints one line per transaction.
// -----------------------------------------------------------------------------
module tb_pipe_pack;

    localparam int DW = 8;
    localparam int RT = 4;

    logic              clk;
    logic              rstn;
    logic [DW-1:0]     i_data;
    logic              i_valid;
    logic              i_last;
    logic              o_ready;
    logic [DW*RT-1:0]  o_data;
    logic [RT-1:0]     o_keep;
    logic              o_last;
    logic              o_valid;
    logic              i_ready;

    pipe_pack #(.DWIDTH(DW), .RATIO(RT)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    typedef struct packed {
        int unsigned      n;
        logic [3:0][7:0]  beats;
        logic             last;
        logic [31:0]      exp_data;
        logic [3:0]       exp_keep;
        logic             exp_last;
    } vec_t;

    word_t exp_q[$];
    int    pop_cyc[$];
    int    total = 0;
    int    bad   = 0;
    int    cycle = 0;
    int    ready_drops = 0;
    bit    stream_mode = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every wide transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (rstn && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got data=0x%08h keep=%b last=%b, none expected",
                         o_data, o_keep, o_last);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                pop_cyc.push_back(cycle);
                $display("word cyc=%0d data=0x%08h keep=%b last=%b (want 0x%08h %b %b)",
                         cycle, o_data, o_keep, o_last, w.data, w.keep, w.last);
                chk("word_data", o_data, w.data);
                chk("word_keep", 32'(o_keep), 32'(w.keep));
                chk("word_last", 32'(o_last), 32'(w.last));
            end
        end
        if (stream_mode && !o_ready) ready_drops++;
    end

    // Present a beat until it is accepted. Input changes land 1 unit after posedge.
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        t = 0;
        @(negedge clk);
        while (!o_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: beat 0x%02h not accepted within 50 cycles", d);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 32'h44332211, 4'b1111, 1'b0};
        vecs[1] = '{2, {8'h00, 8'h00, 8'hBB, 8'hAA}, 1'b1, 32'h0000BBAA, 4'b0011, 1'b1};
        vecs[2] = '{4, {8'hFF, 8'hEE, 8'hDD, 8'hCC}, 1'b0, 32'hFFEEDDCC, 4'b1111, 1'b0};
        vecs[3] = '{1, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b1, 32'h0000005A, 4'b0001, 1'b1};
        vecs[4] = '{4, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 1'b1, 32'hD4C3B2A1, 4'b1111, 1'b1};
        vecs[5] = '{3, {8'h00, 8'h03, 8'h02, 8'h01}, 1'b1, 32'h00030201, 4'b0111, 1'b1};

        rstn    = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;

        // Reset state, with i_valid high to show that o_ready stays gated low.
        idle(2);
        i_valid = 1'b1;
        @(negedge clk);
        chk("rst_o_ready", 32'(o_ready), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data",  o_data, 32'd0);
        chk("rst_o_keep",  32'(o_keep), 32'd0);
        chk("rst_o_last",  32'(o_last), 32'd0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        rstn    = 1'b1;
        idle(1);

        // Table-driven words.
        for (int v = 0; v < 6; v++) begin
            push(vecs[v].exp_data, vecs[v].exp_keep, vecs[v].exp_last);
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                send(vecs[v].beats[j], vecs[v].last && (j == int'(vecs[v].n) - 1));
            end
        end
        idle(3);

        // Back-to-back stream of 12 beats at full rate.
        pop_cyc.delete();
        push(32'h04030201, 4'b1111, 1'b0);
        push(32'h08070605, 4'b1111, 1'b0);
        push(32'h0C0B0A09, 4'b1111, 1'b0);
        stream_mode = 1;
        for (int b = 1; b <= 12; b++) begin
            send(8'(b), 1'b0);
        end
        idle(2);
        stream_mode = 0;
        chk("stream_ready_drops", 32'(ready_drops), 32'd0);
        chk("stream_word_count", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() == 3) begin
            chk("stream_gap_1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd4);
            chk("stream_gap_2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd4);
        end

        // Backpressure: hold the word 7 cycles with the next beat pending.
        i_ready = 1'b0;
        push(32'h04030201, 4'b1111, 1'b0);
        push(32'h00000005, 4'b0001, 1'b1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        i_valid = 1'b1;
        i_data  = 8'h05;
        i_last  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("bp_o_valid", 32'(o_valid), 32'd1);
            chk("bp_o_ready", 32'(o_ready), 32'd0);
            chk("bp_o_data",  o_data, 32'h04030201);
            chk("bp_o_keep",  32'(o_keep), 32'hF);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        @(negedge clk);
        chk("bp_ready_after", 32'(o_ready), 32'd1);
        idle(3);

        // Reset mid-word discards the partial lanes 0x11, 0x22.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_o_ready", 32'(o_ready), 32'd0);
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        push(32'h66554433, 4'b1111, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);

        // Drain with a bound.
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
            @(posedge clk);
        end
        idle(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
